uart_rx: RTL

//  Receive path for the UART peripheral; the partner of the existing transmitter on the same serial link.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and bit-period derivation.
// Used by both the receive and transmit sides so their bit timing always agrees.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int clocks_per_bit(input int clock_speed, input int baud_rate);
    return clock_speed / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, 2 clk latency, no backpressure.
// Resets to RST_VAL so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling mid-bit; byte valid ~9.5 bit periods + 3 clk after the start edge.
// Holds one byte on a valid/ready handshake; a byte arriving while the held one is unconsumed is dropped and flagged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_SPEED = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CLOCKS_PER_BIT = clocks_per_bit(CLOCK_SPEED, BAUD_RATE);
  localparam int HALF           = CLOCKS_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W          = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if (CLOCKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLOCKS_PER_BIT must be at least 4");
  end

  logic                 rx_s;
  logic                 rx_d;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d <= 1'b1;
    end else begin
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          cnt <= '0;
          // Edge-triggered so a line stuck low after a framing error stays quiet.
          if (rx_d && !rx_s) begin
            state   <= RX_START;
            rx_busy <= 1'b1;
          end
        end

        RX_START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              state   <= RX_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RX_STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a following start edge.
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= RX_IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
